// File: rtl/tlb_if.sv
// tlb_if: translation request/response bus between the mapping stage and the TLB
interface tlb_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_vaddr;
    logic        req_store;
    logic        resp_valid;
    logic [31:0] resp_paddr;
    logic        resp_uncached;
    logic        resp_miss;
    logic        resp_invalid;
    logic        resp_modified;

    modport master (
        output req_valid, req_vaddr, req_store,
        input  req_ready, resp_valid, resp_paddr, resp_uncached, resp_miss, resp_invalid, resp_modified
    );

    modport slave (
        input  req_valid, req_vaddr, req_store,
        output req_ready, resp_valid, resp_paddr, resp_uncached, resp_miss, resp_invalid, resp_modified
    );
endinterface

// File: rtl/tlb_unit.sv
// tlb_unit: joint software-managed TLB with lookup, TLBWI/TLBWR, TLBP, TLBR and Random
module tlb_unit #(
    parameter  int ENTRIES = 16,
    localparam int IW      = $clog2(ENTRIES)
) (
    input  logic          clk,
    input  logic          rst_n,
    tlb_if.slave          bus,
    input  logic [7:0]    asid,
    input  logic          wr_en,
    input  logic          wr_random,
    input  logic [IW-1:0] wr_index,
    input  logic [31:0]   entry_hi,
    input  logic [31:0]   entry_lo0,
    input  logic [31:0]   entry_lo1,
    input  logic          probe_en,
    output logic          probe_done,
    output logic          probe_miss,
    output logic [IW-1:0] probe_index,
    input  logic          rd_en,
    output logic          rd_done,
    output logic [31:0]   rd_hi,
    output logic [31:0]   rd_lo0,
    output logic [31:0]   rd_lo1,
    input  logic [IW-1:0] wired_i,
    output logic [IW-1:0] random_o
);
    localparam logic [IW-1:0] LAST = IW'(ENTRIES - 1);

    logic [ENTRIES-1:0] present, gbit, d0, d1, v0, v1;
    logic [18:0]        vpn2  [ENTRIES];
    logic [7:0]         easid [ENTRIES];
    logic [19:0]        pfn0  [ENTRIES];
    logic [19:0]        pfn1  [ENTRIES];
    logic [2:0]         c0    [ENTRIES];
    logic [2:0]         c1    [ENTRIES];

    logic [ENTRIES-1:0] l_match, p_match;
    logic               l_hit, p_hit;
    logic [IW-1:0]      l_idx, p_idx;
    logic [IW-1:0]      widx;
    logic               accept, do_probe, do_read;
    logic               odd, sel_d, sel_v, miss, inval, modf, fault;
    logic [19:0]        sel_pfn;
    logic [2:0]         sel_c;
    logic               unused;

    assign unused    = ^{entry_hi[12:8], entry_lo0[31:26], entry_lo1[31:26]};
    assign accept    = bus.req_valid & ~wr_en;
    assign bus.req_ready = ~wr_en;
    assign do_probe  = probe_en & ~wr_en;
    assign do_read   = rd_en & ~wr_en & ~probe_en;
    assign widx      = wr_random ? random_o : wr_index;

    for (genvar g = 0; g < ENTRIES; g++) begin : g_match
        assign l_match[g] = present[g] && vpn2[g] == bus.req_vaddr[31:13] && (gbit[g] || easid[g] == asid);
        assign p_match[g] = present[g] && vpn2[g] == entry_hi[31:13] && (gbit[g] || easid[g] == entry_hi[7:0]);
    end

    // Lowest matching index wins for both the lookup and the probe port
    always_comb begin
        l_hit = |l_match;
        p_hit = |p_match;
        l_idx = '0;
        p_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (l_match[i]) l_idx = IW'(i);
            if (p_match[i]) p_idx = IW'(i);
        end
    end

    assign odd     = bus.req_vaddr[12];
    assign sel_pfn = odd ? pfn1[l_idx] : pfn0[l_idx];
    assign sel_c   = odd ? c1[l_idx] : c0[l_idx];
    assign sel_d   = odd ? d1[l_idx] : d0[l_idx];
    assign sel_v   = odd ? v1[l_idx] : v0[l_idx];
    assign miss    = ~l_hit;
    assign inval   = l_hit & ~sel_v;
    assign modf    = l_hit & sel_v & ~sel_d & bus.req_store;
    assign fault   = miss | inval | modf;

    // Entry storage: a write overwrites every field of the selected pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            present <= '0;
            gbit    <= '0;
            d0      <= '0;
            d1      <= '0;
            v0      <= '0;
            v1      <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                vpn2[i]  <= '0;
                easid[i] <= '0;
                pfn0[i]  <= '0;
                pfn1[i]  <= '0;
                c0[i]    <= '0;
                c1[i]    <= '0;
            end
        end else if (wr_en) begin
            present[widx] <= 1'b1;
            gbit[widx]    <= entry_lo0[0] & entry_lo1[0];
            vpn2[widx]    <= entry_hi[31:13];
            easid[widx]   <= entry_hi[7:0];
            pfn0[widx]    <= entry_lo0[25:6];
            c0[widx]      <= entry_lo0[5:3];
            d0[widx]      <= entry_lo0[2];
            v0[widx]      <= entry_lo0[1];
            pfn1[widx]    <= entry_lo1[25:6];
            c1[widx]      <= entry_lo1[5:3];
            d1[widx]      <= entry_lo1[2];
            v1[widx]      <= entry_lo1[1];
        end
    end

    // Registered lookup result; faults force a zero address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.resp_valid    <= 1'b0;
            bus.resp_paddr    <= '0;
            bus.resp_uncached <= 1'b0;
            bus.resp_miss     <= 1'b0;
            bus.resp_invalid  <= 1'b0;
            bus.resp_modified <= 1'b0;
        end else begin
            bus.resp_valid <= accept;
            if (accept) begin
                bus.resp_paddr    <= fault ? 32'h0 : {sel_pfn, bus.req_vaddr[11:0]};
                bus.resp_uncached <= ~fault & (sel_c == 3'b010);
                bus.resp_miss     <= miss;
                bus.resp_invalid  <= inval;
                bus.resp_modified <= modf;
            end
        end
    end

    // Probe and read results, each with its own one-cycle done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            probe_done  <= 1'b0;
            probe_miss  <= 1'b0;
            probe_index <= '0;
            rd_done     <= 1'b0;
            rd_hi       <= '0;
            rd_lo0      <= '0;
            rd_lo1      <= '0;
        end else begin
            probe_done <= do_probe;
            rd_done    <= do_read;
            if (do_probe) begin
                probe_miss  <= ~p_hit;
                probe_index <= p_idx;
            end
            if (do_read) begin
                rd_hi  <= present[wr_index] ? {vpn2[wr_index], 5'b0, easid[wr_index]} : 32'h0;
                rd_lo0 <= present[wr_index] ? {6'b0, pfn0[wr_index], c0[wr_index], d0[wr_index], v0[wr_index], gbit[wr_index]} : 32'h0;
                rd_lo1 <= present[wr_index] ? {6'b0, pfn1[wr_index], c1[wr_index], d1[wr_index], v1[wr_index], gbit[wr_index]} : 32'h0;
            end
        end
    end

    // Random counts down and wraps to the top once it reaches wired
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) random_o <= LAST;
        else        random_o <= (random_o <= wired_i) ? LAST : random_o - IW'(1);
    end
endmodule

// File: tb/tb_tlb_unit.sv
// tb_tlb_unit: directed self-checking bench for tlb_unit
module tb_tlb_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  asid;
    logic        wr_en, wr_random, probe_en, rd_en;
    logic [3:0]  wr_index, wired_i;
    logic [31:0] entry_hi, entry_lo0, entry_lo1;
    logic        probe_done, probe_miss, rd_done;
    logic [3:0]  probe_index, random_o;
    logic [31:0] rd_hi, rd_lo0, rd_lo1;
    int          n_checks = 0;
    int          n_errors = 0;

    tlb_if bus();

    tlb_unit #(.ENTRIES(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .asid(asid),
        .wr_en(wr_en), .wr_random(wr_random), .wr_index(wr_index),
        .entry_hi(entry_hi), .entry_lo0(entry_lo0), .entry_lo1(entry_lo1),
        .probe_en(probe_en), .probe_done(probe_done), .probe_miss(probe_miss), .probe_index(probe_index),
        .rd_en(rd_en), .rd_done(rd_done), .rd_hi(rd_hi), .rd_lo0(rd_lo0), .rd_lo1(rd_lo1),
        .wired_i(wired_i), .random_o(random_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic lookup(input logic [31:0] va, input logic st);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_vaddr = va;
        bus.req_store = st;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic write(input logic rnd, input logic [3:0] idx, input logic [31:0] hi, input logic [31:0] lo0, input logic [31:0] lo1);
        @(negedge clk);
        wr_en = 1'b1;
        wr_random = rnd;
        wr_index = idx;
        entry_hi = hi;
        entry_lo0 = lo0;
        entry_lo1 = lo1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic read(input logic [3:0] idx);
        @(negedge clk);
        rd_en = 1'b1;
        wr_index = idx;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic probe(input logic [31:0] hi);
        @(negedge clk);
        probe_en = 1'b1;
        entry_hi = hi;
        @(posedge clk);
        #1;
        probe_en = 1'b0;
    endtask

    task automatic check_resp(input string tag, input logic [31:0] pa, input logic [3:0] flags);
        check({tag, " valid"}, 32'(bus.resp_valid), 32'h1);
        check({tag, " paddr"}, bus.resp_paddr, pa);
        check({tag, " flags"}, {28'h0, bus.resp_uncached, bus.resp_miss, bus.resp_invalid, bus.resp_modified}, {28'h0, flags});
    endtask

    initial begin
        logic [3:0] seq10 [9] = '{4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd15, 4'd14, 4'd13, 4'd12};
        bus.req_valid = 1'b0;
        bus.req_vaddr = '0;
        bus.req_store = 1'b0;
        asid = 8'd5;
        {wr_en, wr_random, probe_en, rd_en} = '0;
        wr_index = '0;
        wired_i = '0;
        {entry_hi, entry_lo0, entry_lo1} = '0;

        do_reset();
        #1;
        check("rst random", 32'(random_o), 32'd15);
        check("rst ready", 32'(bus.req_ready), 32'h1);
        check("rst pulses", {29'h0, bus.resp_valid, probe_done, rd_done}, 32'h0);
        check("rst outs", bus.resp_paddr | 32'(probe_miss) | rd_hi | rd_lo0 | rd_lo1, 32'h0);
        for (int k = 14; k >= 0; k--) begin
            @(posedge clk);
            #1;
            check($sformatf("random w0 %0d", k), 32'(random_o), 32'(k));
        end
        @(posedge clk);
        #1;
        check("random w0 wrap", 32'(random_o), 32'd15);

        lookup(32'h0040_0000, 1'b0);
        check_resp("empty miss", 32'h0, 4'b0100);
        @(posedge clk);
        #1;
        check("resp pulse", 32'(bus.resp_valid), 32'h0);

        write(1'b0, 4'd3, 32'h0040_0005, 32'h0000_48DE, 32'h0001_159C);
        lookup(32'h0040_0ABC, 1'b0);
        check_resp("hit even", 32'h0012_3ABC, 4'b0000);
        asid = 8'd6;
        lookup(32'h0040_0ABC, 1'b0);
        check_resp("asid miss", 32'h0, 4'b0100);
        asid = 8'd5;
        lookup(32'h0040_1000, 1'b0);
        check_resp("odd invalid", 32'h0, 4'b0010);

        write(1'b0, 4'd4, 32'h0080_0000, 32'h0000_801B, 32'h0000_8057);
        lookup(32'h0080_0010, 1'b1);
        check_resp("store clean", 32'h0, 4'b0001);
        lookup(32'h0080_0010, 1'b0);
        check_resp("load clean", 32'h0020_0010, 4'b0000);
        asid = 8'd99;
        lookup(32'h0080_1020, 1'b1);
        check_resp("global uncached", 32'h0020_1020, 4'b1000);
        asid = 8'd5;

        @(negedge clk);
        wr_en = 1'b1;
        wr_random = 1'b0;
        wr_index = 4'd5;
        entry_hi = 32'h00C0_0005;
        entry_lo0 = 32'h0000_C01E;
        entry_lo1 = 32'h0;
        bus.req_valid = 1'b1;
        bus.req_vaddr = 32'h00C0_0004;
        bus.req_store = 1'b0;
        #1;
        check("ready low on write", 32'(bus.req_ready), 32'h0);
        @(posedge clk);
        #1;
        check("no accept on write", 32'(bus.resp_valid), 32'h0);
        @(negedge clk);
        wr_en = 1'b0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check_resp("after write", 32'h0030_0004, 4'b0000);

        lookup(32'h0040_0ABC, 1'b0);
        rst_n = 1'b0;
        #1;
        check("reset drops resp", 32'(bus.resp_valid), 32'h0);
        check("reset clears paddr", bus.resp_paddr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        lookup(32'h0040_0ABC, 1'b0);
        check_resp("cleared miss", 32'h0, 4'b0100);
        read(4'd3);
        check("absent rd_done", 32'(rd_done), 32'h1);
        check("absent read", rd_hi | rd_lo0 | rd_lo1, 32'h0);

        wired_i = 4'd10;
        do_reset();
        #1;
        check("random w10 start", 32'(random_o), 32'd15);
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("random w10 step %0d", k), 32'(random_o), 32'(seq10[k]));
        end
        write(1'b1, 4'd0, 32'h1234_6022, 32'h002A_F35F, 32'h0000_4453);
        read(4'd12);
        check("tlbr done", 32'(rd_done), 32'h1);
        check("tlbr hi", rd_hi, 32'h1234_6022);
        check("tlbr lo0", rd_lo0, 32'h002A_F35F);
        check("tlbr lo1", rd_lo1, 32'h0000_4453);
        @(posedge clk);
        #1;
        check("rd_done pulse", 32'(rd_done), 32'h0);
        probe(32'h1234_6022);
        check("probe hit", {27'h0, probe_done, probe_miss, probe_index}, {27'h0, 1'b1, 1'b0, 4'd12});
        probe(32'h7000_0000);
        check("probe miss", {27'h0, probe_done, probe_miss, probe_index}, {27'h0, 1'b1, 1'b1, 4'd0});
        @(posedge clk);
        #1;
        check("probe_done pulse", 32'(probe_done), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
